dense_backward_block: RTL



---
 rtl/dense_backward_block_pkg.sv | 44 ++++
 rtl/dense_backward_block_if.sv | 16 +
 rtl/dense_backward_mac_lanes.sv | 44 ++++
 rtl/dense_backward_block.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dense_backward_block_pkg.sv
// Shared constants, FSM state type and output saturation helper for the
// dense-layer backward pass (dx = W^T * dy).
package dense_backward_block_pkg;

   localparam int DATA_N   = 8;    // weights per memory word
   localparam int HID_DIM  = 24;   // hidden width, multiple of DATA_N
   localparam int CHAR_NUM = 200;  // output classes (rows of W)
   localparam int N_LEN    = 16;   // dy / q width
   localparam int N_LEN_W  = 16;   // weight width
   localparam int FRAC_W   = 8;    // fractional bits of the weights
   localparam int ACC_W    = 24;   // accumulator width
   localparam int ADDR_W   = 10;   // weight address width

   localparam int K_N    = HID_DIM / DATA_N;           // words per row
   localparam int N_RD   = CHAR_NUM * K_N;             // words per job
   localparam int K_W    = (K_N > 1) ? $clog2(K_N) : 1;
   localparam int C_W    = $clog2(CHAR_NUM);
   localparam int PROD_W = N_LEN + N_LEN_W;

   localparam logic signed [ACC_W-1:0] ACC_QMAX = ACC_W'((1 << (N_LEN - 1)) - 1);
   localparam logic signed [ACC_W-1:0] ACC_QMIN = ACC_W'(-(1 << (N_LEN - 1)));

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   // Clamp a wrapped accumulator value into the signed N_LEN output range.
   function automatic logic [N_LEN-1:0] sat_to_q(input logic [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] sv;
      logic [N_LEN-1:0]        res;
      sv = $signed(v);
      if (sv > ACC_QMAX)
         res = {1'b0, {(N_LEN-1){1'b1}}};
      else if (sv < ACC_QMIN)
         res = {1'b1, {(N_LEN-1){1'b0}}};
      else
         res = v[N_LEN-1:0];
      return res;
   endfunction

endpackage

// File: rtl/dense_backward_block_if.sv
// Job / weight-memory / result bundle of the dense backward block.
// slave = the block itself, master = the surrounding datapath (or a bench).
interface dense_backward_block_if;
   import dense_backward_block_pkg::*;

   logic                        run;
   logic [CHAR_NUM*N_LEN-1:0]   dy;
   logic [ADDR_W-1:0]           raddr;
   logic [DATA_N*N_LEN_W-1:0]   rdata;
   logic                        valid;
   logic [HID_DIM*N_LEN-1:0]    q;

   modport master (output run, dy, rdata, input raddr, valid, q);
   modport slave  (input run, dy, rdata, output raddr, valid, q);

endinterface

// File: rtl/dense_backward_mac_lanes.sv
// DATA_N parallel signed multipliers: p_j = (w_j * dy) >>> FRAC_W, registered,
// with a valid bit travelling alongside (1-cycle latency).
module dense_backward_mac_lanes
   import dense_backward_block_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid_i,
   input  logic [DATA_N*N_LEN_W-1:0]         w_i,
   input  logic signed [N_LEN-1:0]           dy_i,
   output logic [DATA_N-1:0][ACC_W-1:0]      p_o,
   output logic                              out_valid_o
);

   logic [DATA_N-1:0][ACC_W-1:0] p_d;
   logic [DATA_N-1:0][ACC_W-1:0] p_q;
   logic                         valid_q;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_N; gi++) begin : g_lane
         logic signed [PROD_W-1:0] prod;
         // Full-width signed product; the arithmetic shift floors toward -inf
         // and the size cast truncates (or sign-extends) to the accumulator.
         assign prod    = $signed(w_i[gi*N_LEN_W +: N_LEN_W]) * dy_i;
         assign p_d[gi] = ACC_W'(prod >>> FRAC_W);
      end
   endgenerate

   // Register the lane products and their valid bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         p_q     <= p_d;
         valid_q <= in_valid_i;
      end
   end

   assign p_o         = p_q;
   assign out_valid_o = valid_q;

endmodule

// File: rtl/dense_backward_block.sv
// Dense-layer backward pass: streams the row-major weight memory once,
// multiplies each word by dy[row] in DATA_N lanes and accumulates into a
// HID_DIM-entry bank, then publishes the saturated bank on q.
module dense_backward_block
   import dense_backward_block_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   dense_backward_block_if.slave bus
);

   state_t                       state_q, state_d;
   logic [ADDR_W-1:0]            addr_q, addr_d;
   logic [C_W-1:0]               c_q, c_d;
   logic [K_W-1:0]               k_q, k_d;
   logic                         sample;    // memory samples a real address this edge
   logic                         load_q;    // publish the bank on this edge

   // Stage 1: row/column of the word now on rdata.
   logic                         s1_valid_q;
   logic [C_W-1:0]               s1_c_q;
   logic [K_W-1:0]               s1_k_q;
   // Stage 2: column of the products now leaving the MAC lanes.
   logic [K_W-1:0]               s2_k_q;

   logic                         mac_in_valid;
   logic                         mac_vld;
   logic [DATA_N-1:0][ACC_W-1:0] mac_p;
   logic signed [N_LEN-1:0]      dy_sel;

   logic [ACC_W-1:0]             acc_q [HID_DIM];
   logic [N_LEN-1:0]             q_q   [HID_DIM];
   logic [HID_DIM*N_LEN-1:0]     q_flat;

   // Next state, address/row/column counters and job strobes.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      c_d     = c_q;
      k_d     = k_q;
      sample  = 1'b0;
      load_q  = 1'b0;
      if (!bus.run) begin
         state_d = S_IDLE;
         addr_d  = '0;
         c_d     = '0;
         k_d     = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Address 0 is sampled on this very edge.
               sample  = 1'b1;
               state_d = S_ISSUE;
               addr_d  = addr_q + 1'b1;
               if (k_q == K_W'(K_N - 1)) begin
                  k_d = '0;
                  c_d = c_q + 1'b1;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
            S_ISSUE: begin
               sample = 1'b1;
               if (addr_q == ADDR_W'(N_RD - 1)) begin
                  // Last word sampled: hold the address, let the pipe drain.
                  state_d = S_DRAIN;
               end else begin
                  addr_d = addr_q + 1'b1;
                  if (k_q == K_W'(K_N - 1)) begin
                     k_d = '0;
                     c_d = c_q + 1'b1;
                  end else begin
                     k_d = k_q + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               // Both pipeline stages empty means the bank holds the full sum.
               if (!s1_valid_q && !mac_vld) begin
                  state_d = S_DONE;
                  load_q  = 1'b1;
               end
            end
            default: ;  // S_DONE holds until run drops
         endcase
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         c_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         c_q     <= c_d;
         k_q     <= k_d;
      end
   end

   // Delay row/column so they line up with rdata and then with the products.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_c_q     <= '0;
         s1_k_q     <= '0;
         s2_k_q     <= '0;
      end else begin
         s1_valid_q <= sample;
         s1_c_q     <= c_q;
         s1_k_q     <= k_q;
         s2_k_q     <= s1_k_q;
      end
   end

   assign dy_sel       = bus.dy[s1_c_q*N_LEN +: N_LEN];
   assign mac_in_valid = s1_valid_q & bus.run;

   dense_backward_mac_lanes u_mac (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (mac_in_valid),
      .w_i         (bus.rdata),
      .dy_i        (dy_sel),
      .p_o         (mac_p),
      .out_valid_o (mac_vld)
   );

   // Accumulator bank: column k of the current word feeds entries k*DATA_N+j.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int h = 0; h < HID_DIM; h++) acc_q[h] <= '0;
      end else if (!bus.run || state_q == S_IDLE) begin
         for (int h = 0; h < HID_DIM; h++) acc_q[h] <= '0;
      end else if (mac_vld) begin
         for (int h = 0; h < HID_DIM; h++) begin
            if (s2_k_q == K_W'(h / DATA_N))
               acc_q[h] <= acc_q[h] + mac_p[h % DATA_N];
         end
      end
   end

   // Result register: only a completed job overwrites it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int h = 0; h < HID_DIM; h++) q_q[h] <= '0;
      end else if (load_q) begin
         for (int h = 0; h < HID_DIM; h++) q_q[h] <= sat_to_q(acc_q[h]);
      end
   end

   // Pack the result entries onto the output bus.
   always_comb begin
      q_flat = '0;
      for (int h = 0; h < HID_DIM; h++) q_flat[h*N_LEN +: N_LEN] = q_q[h];
   end

   assign bus.q     = q_flat;
   assign bus.raddr = addr_q;
   assign bus.valid = (state_q == S_DONE) && bus.run;

endmodule
